// File: rtl/safecrack_param_fsm.sv
// Parametrised safe-lock controller: edge-detected code entry, error lockout with
// a seconds display, double-entry code change and optional auto-relock while open.
module safecrack_param_fsm #(
  parameter int NUM_BTN       = 4,
  parameter int CODE_LEN      = 3,
  parameter int MAX_ERRORS    = 3,
  parameter int LOCK_SECONDS  = 10,
  parameter int AUTO_RELOCK_S = 0,
  parameter int CLK_HZ        = 50_000_000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ms,
  input  logic                    lock,
  input  logic [NUM_BTN-1:0]      btn,
  output logic                    unlocked,
  output logic                    program_mode,
  output logic                    locked_out,
  output logic                    prog_fail,
  output logic [MAX_ERRORS-1:0]   leds_erros,
  output logic [CODE_LEN-1:0]     leds_acertos,
  output logic [LOCK_SECONDS-1:0] leds_segundos
);
  localparam int IW = $clog2(CODE_LEN + 1);
  localparam int EW = $clog2(MAX_ERRORS + 1);
  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [NUM_BTN-1:0] NO_PRESS   = {NUM_BTN{1'b1}};
  localparam logic [IW-1:0]      LAST_IDX   = IW'(CODE_LEN - 1);
  localparam logic [EW-1:0]      ERR_MAX    = EW'(MAX_ERRORS);
  localparam logic [PW-1:0]      PRESC_TOP  = PW'(CLK_HZ - 1);
  localparam logic [5:0]         LOCK_SEC   = 6'(LOCK_SECONDS);
  localparam logic [5:0]         RELOCK_SEC = 6'(AUTO_RELOCK_S);
  localparam bit                 AUTO_EN    = (AUTO_RELOCK_S > 0);

  typedef enum logic [2:0] {
    ST_ENTRY     = 3'd0,
    ST_OPEN      = 3'd1,
    ST_LOCKOUT   = 3'd2,
    ST_PROG_NEW  = 3'd3,
    ST_PROG_CONF = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [EW-1:0]      err_q, err_d;
  logic [5:0]         sec_q, sec_d;
  logic [PW-1:0]      presc_q, presc_d;
  logic [NUM_BTN-1:0] btn_q;
  logic [NUM_BTN-1:0] code_q   [CODE_LEN];
  logic [NUM_BTN-1:0] code_d   [CODE_LEN];
  logic [NUM_BTN-1:0] shadow_q [CODE_LEN];
  logic [NUM_BTN-1:0] shadow_d [CODE_LEN];
  logic [NUM_BTN-1:0] cur_code_s, cur_shadow_s;
  logic               press_s, run_s, tick_s, restart_s, prog_fail_d;
  logic [5:0]         sec_inc_s;
  logic [MAX_ERRORS-1:0]   erros_d;
  logic [CODE_LEN-1:0]     acertos_d;
  logic [LOCK_SECONDS-1:0] segundos_d;

  function automatic logic [NUM_BTN-1:0] default_digit(input int i);
    default_digit = ~(NUM_BTN'(1) << (i % NUM_BTN));
  endfunction

  assign press_s   = (btn_q == NO_PRESS) && (btn != NO_PRESS);
  assign run_s     = (state_q == ST_LOCKOUT) || ((state_q == ST_OPEN) && AUTO_EN);
  assign tick_s    = run_s && (presc_q == PRESC_TOP);
  assign sec_inc_s = sec_q + 6'd1;

  // idx is one bit wider than the digit arrays need, so select by compare rather than index
  always_comb begin
    cur_code_s   = {NUM_BTN{1'b0}};
    cur_shadow_s = {NUM_BTN{1'b0}};
    for (int i = 0; i < CODE_LEN; i++) begin
      cur_code_s   = cur_code_s   | (code_q[i]   & {NUM_BTN{idx_q == IW'(i)}});
      cur_shadow_s = cur_shadow_s | (shadow_q[i] & {NUM_BTN{idx_q == IW'(i)}});
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    err_d       = err_q;
    code_d      = code_q;
    shadow_d    = shadow_q;
    prog_fail_d = 1'b0;
    restart_s   = 1'b0;
    case (state_q)
      ST_ENTRY: begin
        if (press_s && (btn == cur_code_s)) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_OPEN;
            idx_d   = {IW{1'b0}};
            err_d   = {EW{1'b0}};
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else if (press_s) begin
          idx_d = {IW{1'b0}};
          if ((err_q + EW'(1)) == ERR_MAX) begin
            err_d   = ERR_MAX;
            state_d = ST_LOCKOUT;
          end else begin
            err_d = err_q + EW'(1);
          end
        end else begin
          idx_d = idx_q;
        end
      end
      ST_LOCKOUT: begin
        if (tick_s && (sec_inc_s == LOCK_SEC)) begin
          state_d = ST_ENTRY;
          err_d   = {EW{1'b0}};
        end else begin
          state_d = ST_LOCKOUT;
        end
      end
      ST_OPEN: begin
        if (lock) begin
          state_d = ST_ENTRY;
        end else if (ms) begin
          state_d = ST_PROG_NEW;
          idx_d   = {IW{1'b0}};
        end else if (AUTO_EN && tick_s && (sec_inc_s == RELOCK_SEC)) begin
          state_d = ST_ENTRY;
        end else begin
          restart_s = press_s;
        end
      end
      ST_PROG_NEW: begin
        if (!ms) begin
          state_d = ST_OPEN;
          idx_d   = {IW{1'b0}};
        end else if (press_s) begin
          for (int i = 0; i < CODE_LEN; i++) begin
            shadow_d[i] = (idx_q == IW'(i)) ? btn : shadow_q[i];
          end
          if (idx_q == LAST_IDX) begin
            state_d = ST_PROG_CONF;
            idx_d   = {IW{1'b0}};
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else begin
          idx_d = idx_q;
        end
      end
      ST_PROG_CONF: begin
        if (!ms) begin
          state_d = ST_OPEN;
          idx_d   = {IW{1'b0}};
        end else if (press_s && (btn == cur_shadow_s)) begin
          if (idx_q == LAST_IDX) begin
            code_d  = shadow_q;
            state_d = ST_ENTRY;
            idx_d   = {IW{1'b0}};
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else if (press_s) begin
          prog_fail_d = 1'b1;
          state_d     = ST_OPEN;
          idx_d       = {IW{1'b0}};
        end else begin
          idx_d = idx_q;
        end
      end
      default: begin
        state_d = ST_ENTRY;
        idx_d   = {IW{1'b0}};
      end
    endcase

    // Timebase restarts on any state change and on a press while open
    if (!run_s || (state_d != state_q) || restart_s) begin
      presc_d = {PW{1'b0}};
      sec_d   = 6'd0;
    end else if (tick_s) begin
      presc_d = {PW{1'b0}};
      sec_d   = sec_inc_s;
    end else begin
      presc_d = presc_q + PW'(1);
      sec_d   = sec_q;
    end
  end

  // Thermometer displays built from the next-state counters
  always_comb begin
    for (int k = 0; k < MAX_ERRORS; k++) begin
      erros_d[k] = (int'(err_d) > k);
    end
    for (int k = 0; k < CODE_LEN; k++) begin
      acertos_d[k] = (state_d == ST_OPEN) || ((state_d == ST_ENTRY) && (int'(idx_d) > k));
    end
    for (int k = 0; k < LOCK_SECONDS; k++) begin
      segundos_d[k] = (state_d == ST_LOCKOUT) && (int'(sec_d) > k);
    end
  end

  // Control state, counters, code storage and button history
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_ENTRY;
      idx_q   <= {IW{1'b0}};
      err_q   <= {EW{1'b0}};
      sec_q   <= 6'd0;
      presc_q <= {PW{1'b0}};
      btn_q   <= NO_PRESS;
      for (int i = 0; i < CODE_LEN; i++) begin
        code_q[i]   <= default_digit(i);
        shadow_q[i] <= NO_PRESS;
      end
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      err_q    <= err_d;
      sec_q    <= sec_d;
      presc_q  <= presc_d;
      btn_q    <= btn;
      code_q   <= code_d;
      shadow_q <= shadow_d;
    end
  end

  // Registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      unlocked      <= 1'b0;
      program_mode  <= 1'b0;
      locked_out    <= 1'b0;
      prog_fail     <= 1'b0;
      leds_erros    <= {MAX_ERRORS{1'b0}};
      leds_acertos  <= {CODE_LEN{1'b0}};
      leds_segundos <= {LOCK_SECONDS{1'b0}};
    end else begin
      unlocked      <= (state_d == ST_OPEN);
      program_mode  <= (state_d == ST_PROG_NEW) || (state_d == ST_PROG_CONF);
      locked_out    <= (state_d == ST_LOCKOUT);
      prog_fail     <= prog_fail_d;
      leds_erros    <= erros_d;
      leds_acertos  <= acertos_d;
      leds_segundos <= segundos_d;
    end
  end
endmodule

// File: tb/tb_safecrack_param_fsm.sv
// Randomised and directed bench for safecrack_param_fsm: two instances (auto-relock off
// and on) checked every cycle against a cycle-count based behavioural model.
module tb_safecrack_param_fsm;
  localparam int NB = 4, CL = 3, ME = 3, LS = 10, CH = 4;
  localparam int AR0 = 0, AR1 = 2;
  localparam int ALL = (1 << NB) - 1;
  localparam int M_ENTRY = 0, M_OPEN = 1, M_LOCK = 2, M_PNEW = 3, M_PCONF = 4;
  localparam int VW = 4 + ME + CL + LS;

  logic clk = 1'b0, rst = 1'b1, ms = 1'b0, lock = 1'b0;
  logic [NB-1:0] btn = '1;
  logic u0, pm0, lo0, pf0, u1, pm1, lo1, pf1;
  logic [ME-1:0] le0, le1;
  logic [CL-1:0] la0, la1;
  logic [LS-1:0] ls0, ls1;
  logic [VW-1:0] got0, got1;

  always #5 clk = ~clk;

  safecrack_param_fsm #(.NUM_BTN(NB), .CODE_LEN(CL), .MAX_ERRORS(ME), .LOCK_SECONDS(LS),
                        .AUTO_RELOCK_S(AR0), .CLK_HZ(CH)) dut0 (
    .clk(clk), .rst(rst), .ms(ms), .lock(lock), .btn(btn), .unlocked(u0),
    .program_mode(pm0), .locked_out(lo0), .prog_fail(pf0), .leds_erros(le0),
    .leds_acertos(la0), .leds_segundos(ls0));

  safecrack_param_fsm #(.NUM_BTN(NB), .CODE_LEN(CL), .MAX_ERRORS(ME), .LOCK_SECONDS(LS),
                        .AUTO_RELOCK_S(AR1), .CLK_HZ(CH)) dut1 (
    .clk(clk), .rst(rst), .ms(ms), .lock(lock), .btn(btn), .unlocked(u1),
    .program_mode(pm1), .locked_out(lo1), .prog_fail(pf1), .leds_erros(le1),
    .leds_acertos(la1), .leds_segundos(ls1));

  assign got0 = {u0, pm0, lo0, pf0, le0, la0, ls0};
  assign got1 = {u1, pm1, lo1, pf1, le1, la1, ls1};

  int n_cmp = 0, n_bad = 0, pf_cnt0 = 0;
  bit chk_en = 1'b0;
  int mode [2], pos [2], errs [2], cyc [2], pf [2], prev [2];
  int code_m [2][CL];
  int shad [2][CL];

  function automatic int therm(input int n, input int w);
    int k;
    k = (n < w) ? n : w;
    return (1 << k) - 1;
  endfunction

  function automatic logic [VW-1:0] exp_vec(input int m);
    int acert, seg;
    acert = (mode[m] == M_OPEN) ? therm(CL, CL) : (mode[m] == M_ENTRY) ? therm(pos[m], CL) : 0;
    seg   = (mode[m] == M_LOCK) ? therm(cyc[m] / CH, LS) : 0;
    return {mode[m] == M_OPEN, (mode[m] == M_PNEW) || (mode[m] == M_PCONF), mode[m] == M_LOCK,
            pf[m] != 0, ME'(therm(errs[m], ME)), CL'(acert), LS'(seg)};
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      mode[m] = M_ENTRY; pos[m] = 0; errs[m] = 0; cyc[m] = 0; pf[m] = 0; prev[m] = ALL;
      for (int i = 0; i < CL; i++) code_m[m][i] = (~(1 << (i % NB))) & ALL;
    end
  endtask

  task automatic model_step(input int m, input int ar);
    int b, old;
    bit press;
    b = int'(btn);
    press = (prev[m] == ALL) && (b != ALL);
    prev[m] = b;
    old = mode[m];
    pf[m] = 0;
    case (mode[m])
      M_ENTRY: if (press) begin
        if (b == code_m[m][pos[m]]) begin
          pos[m]++;
          if (pos[m] == CL) begin mode[m] = M_OPEN; pos[m] = 0; errs[m] = 0; end
        end else begin
          pos[m] = 0; errs[m]++;
          if (errs[m] == ME) mode[m] = M_LOCK;
        end
      end
      M_LOCK: begin
        cyc[m]++;
        if (cyc[m] == LS * CH) begin mode[m] = M_ENTRY; errs[m] = 0; end
      end
      M_OPEN: begin
        if (lock) mode[m] = M_ENTRY;
        else if (ms) begin mode[m] = M_PNEW; pos[m] = 0; end
        else if (ar > 0) begin
          cyc[m]++;
          if (cyc[m] == ar * CH) mode[m] = M_ENTRY;
          else if (press) cyc[m] = 0;
        end
      end
      M_PNEW: begin
        if (!ms) begin mode[m] = M_OPEN; pos[m] = 0; end
        else if (press) begin
          shad[m][pos[m]] = b; pos[m]++;
          if (pos[m] == CL) begin mode[m] = M_PCONF; pos[m] = 0; end
        end
      end
      M_PCONF: begin
        if (!ms) begin mode[m] = M_OPEN; pos[m] = 0; end
        else if (press) begin
          if (b == shad[m][pos[m]]) begin
            pos[m]++;
            if (pos[m] == CL) begin
              for (int i = 0; i < CL; i++) code_m[m][i] = shad[m][i];
              mode[m] = M_ENTRY; pos[m] = 0;
            end
          end else begin
            pf[m] = 1; mode[m] = M_OPEN; pos[m] = 0;
          end
        end
      end
      default: mode[m] = M_ENTRY;
    endcase
    if (mode[m] != old) cyc[m] = 0;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else begin
      model_step(0, AR0);
      model_step(1, AR1);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      n_cmp++;
      if (got0 !== exp_vec(0)) begin
        n_bad++;
        $display("FAIL cycle_dut0 @%0t: dut=%h model=%h", $time, got0, exp_vec(0));
      end
      n_cmp++;
      if (got1 !== exp_vec(1)) begin
        n_bad++;
        $display("FAIL cycle_dut1 @%0t: dut=%h model=%h", $time, got1, exp_vec(1));
      end
    end
    if (pf0 === 1'b1) pf_cnt0++;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  task automatic tap(input logic [NB-1:0] d);
    btn = d;
    @(negedge clk);
    btn = '1;
    @(negedge clk);
  endtask

  function automatic int want_digit();
    if (mode[0] == M_PCONF) return shad[0][pos[0]];
    return code_m[0][pos[0]];
  endfunction

  initial begin
    int p;
    repeat (3) @(negedge clk);
    chk("reset_dut0", 32'(got0), 32'h0);
    chk("reset_model", 32'(exp_vec(0)), 32'h0);
    rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);

    tap(4'b1110); chk("acertos_1", 32'(la0), 32'h1);
    tap(4'b1101); chk("acertos_2", 32'(la0), 32'h3);
    tap(4'b1011); chk("acertos_3", 32'(la0), 32'h7); chk("unlocked", 32'(u0), 32'h1);
    chk("model_open", 32'(exp_vec(0)), 32'({1'b1, 3'b000, 3'b000, 3'b111, 10'd0}));
    lock = 1'b1; @(negedge clk); lock = 1'b0;
    chk("relock", 32'(u0), 32'h0);

    btn = 4'b1110; repeat (20) @(negedge clk);
    chk("hold_acertos", 32'(la0), 32'h1); chk("hold_erros", 32'(le0), 32'h0);
    btn = '1; @(negedge clk);
    tap(4'b1101); chk("after_hold", 32'(la0), 32'h3);
    tap(4'b1011); chk("unlock_after_hold", 32'(u0), 32'h1);
    lock = 1'b1; @(negedge clk); lock = 1'b0;

    tap(4'b0111); chk("erros_1", 32'(le0), 32'h1);
    tap(4'b0111); chk("erros_2", 32'(le0), 32'h3);
    tap(4'b0111); chk("erros_3", 32'(le0), 32'h7); chk("locked_out", 32'(lo0), 32'h1);
    repeat (3) @(negedge clk); chk("seg_1", 32'(ls0), 32'h1);
    repeat (4) @(negedge clk); chk("seg_2", 32'(ls0), 32'h3);
    repeat (31) @(negedge clk);
    chk("lock_last", 32'(lo0), 32'h1); chk("seg_9", 32'(ls0), 32'h1FF);
    @(negedge clk);
    chk("lock_exit", 32'(lo0), 32'h0); chk("erros_clr", 32'(le0), 32'h0);
    chk("model_exit", 32'(exp_vec(0)), 32'h0);

    tap(4'b1110); tap(4'b1101); tap(4'b1011);
    ms = 1'b1; @(negedge clk); chk("prog_mode", 32'(pm0), 32'h1);
    tap(4'b0111); tap(4'b0111); tap(4'b1110); chk("prog_conf_mode", 32'(pm0), 32'h1);
    tap(4'b0111); tap(4'b0111); tap(4'b1110); chk("prog_done", 32'({pm0, u0}), 32'h0);
    ms = 1'b0;
    tap(4'b1110); chk("old_code_err", 32'(le0), 32'h1);
    tap(4'b0111); tap(4'b0111); tap(4'b1110); chk("new_code_open", 32'(u0), 32'h1);

    p = pf_cnt0;
    ms = 1'b1; @(negedge clk);
    tap(4'b0111); tap(4'b0111); tap(4'b1110);
    tap(4'b0111);
    btn = 4'b1101; @(negedge clk);
    chk("prog_fail_pulse", 32'(pf0), 32'h1);
    ms = 1'b0; btn = '1; @(negedge clk);
    chk("prog_fail_once", 32'(pf_cnt0 - p), 32'h1);
    chk("fail_open", 32'({u0, pm0, pf0}), 32'h4);
    ms = 1'b1; @(negedge clk);
    tap(4'b0111);
    ms = 1'b0; btn = 4'b1011; @(negedge clk);
    chk("abort_open", 32'({u0, pm0, pf0}), 32'h4);
    btn = '1; @(negedge clk);
    lock = 1'b1; @(negedge clk); lock = 1'b0;
    tap(4'b0111); tap(4'b0111); tap(4'b1110); chk("code_kept", 32'(u0), 32'h1);

    @(negedge clk); #2 rst = 1'b1;
    @(negedge clk); #2 rst = 1'b0;
    @(negedge clk);
    tap(4'b1110); tap(4'b1101); tap(4'b1011);
    chk("default_restored", 32'({u0, u1}), 32'h3);
    repeat (6) @(negedge clk); chk("auto_hold", 32'(u1), 32'h1);
    @(negedge clk);
    chk("auto_relock", 32'(u1), 32'h0); chk("no_auto_dut0", 32'(u0), 32'h1);

    lock = 1'b1; @(negedge clk); lock = 1'b0;
    tap(4'b0111); tap(4'b0111); tap(4'b0111);
    chk("lockout_both", 32'({lo0, lo1}), 32'h3);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("async_rst0", 32'(got0), 32'h0); chk("async_rst1", 32'(got1), 32'h0);
    @(negedge clk); #2 rst = 1'b0;
    @(negedge clk);

    for (int t = 0; t < 3000; t++) begin
      if (btn != '1) begin
        if ($urandom_range(99) < 70) btn = '1;
      end else if ($urandom_range(99) < 35) begin
        if ($urandom_range(99) < 65) btn = NB'(want_digit());
        else btn = NB'($urandom_range(ALL));
      end
      if ($urandom_range(99) < 3) ms = ~ms;
      lock = ($urandom_range(99) < 2);
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
